// File: rtl/mult_seq_unit.sv
// Sequential radix-2 shift-add multiplier: WIDTHxWIDTH -> 2*WIDTH product in hi/lo,
// with a start/busy/done handshake and 33-clock latency for WIDTH=32.
module mult_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    prod;

    // Signed operands are reduced to magnitudes; the sign is reapplied at the end.
    assign mag_a = (sign_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign mag_b = (sign_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign sum   = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign prod  = neg_q ? (~acc_q + PW'(1)) : acc_q;

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = mag_a;
                    neg_d   = sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Carry out of the add becomes the new MSB after the shift.
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                {hi_d, lo_d} = prod;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mult_seq_unit.md
# mult_seq_unit

Sequential 32x32 multiplier producing a 64-bit product in HI/LO registers for the MIPS ALU datapath. Sits beside the bitwise gate arrays (AND/OR/XOR) and adders on the shared `a`/`b` operand buses. Its `hi`/`lo` outputs feed the downstream result mux for `mult`, `multu`, `mfhi` and `mflo`. Uses a radix-2 shift-add iteration with a start/done handshake, so the combinational gate stages stay single-cycle.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH bits. Only 32 is verified.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only when idle
- sign_mode  input  1  1 = signed (`mult`), 0 = unsigned (`multu`); sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when hi/lo are updated
- hi  output  WIDTH  upper half of the last completed product
- lo  output  WIDTH  lower half of the last completed product

## Operation
- States: IDLE, RUN, FINISH.
- Reset behaviour:
  - The state machine returns to IDLE.
  - All outputs go to 0: busy=0, done=0, hi=0, lo=0.
  - All internal registers (accumulator, counter, negate flag) clear to 0.
- IDLE with start=1:
  - Latch mcand and mplier. In signed mode each is replaced by its two's-complement magnitude when its bit 31 is set; in unsigned mode they are taken as-is.
  - neg = sign_mode & (a[31] ^ b[31]).
  - Load the 64-bit accumulator with {32'h0, mplier} and set the counter to 0.
  - Go to RUN and set busy=1.
- RUN, once per cycle:
  - If acc[0]=1, add mcand to acc[63:32] with a 33-bit carry.
  - Shift {carry, acc} right by one bit.
  - Increment the counter. After the 32nd iteration go to FINISH.
- FINISH:
  - {hi, lo} <= neg ? (~acc + 1) : acc.
  - Pulse done=1 and set busy=0, then return to IDLE.
- start while busy=1 is ignored; the in-flight operands are unaffected.
- start in the cycle where done=1 is accepted, since the state is IDLE by then. Back-to-back operations are allowed.
- Operand magnitude 2^31 (signed 0x80000000) is handled as an unsigned 32-bit magnitude. The product of two such magnitudes, 2^62, fits in 64 bits.
- A negated zero product yields 0.
- hi/lo hold their value between completions and are read freely by the downstream mux.

## Timing
- Edge 0: start sampled high. busy reads 1 after edge 0.
- Edges 1..32: the 32 RUN iterations.
- Edge 33: hi/lo are written and done=1 for the cycle after edge 33. busy=0 in that same cycle.
- Total latency: 33 clocks from the start edge to done. Throughput: one product per 33 clocks.
- Reset is asynchronous and immediate. Asserting rst_n low mid-operation aborts the operation and clears hi/lo.
- After rst_n deasserts, the first start is accepted on the next rising edge.

## Test plan
- Unsigned small: a=3, b=5, sign_mode=0 -> done at edge 33, hi=0x00000000, lo=0x0000000F, and busy high for exactly 33 cycles.
- Unsigned max: a=b=0xFFFFFFFF, sign_mode=0 -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed cases, sign_mode=1:
  - a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - a=b=0xFFFFFFFF -> hi=0, lo=1.
  - a=b=0x80000000 -> hi=0x40000000, lo=0.
- Start while busy: at edge 10, assert start with a=7, b=7 -> ignored. The original product still completes at edge 33 and no extra done pulse occurs.
- Reset mid-op: rst_n low at edge 12 -> busy, done, hi and lo read 0 immediately. After release, start with a=2, b=9 -> lo=18 exactly 33 clocks later.
- Back-to-back: start held high through the done cycle with new operands a=0, b=0x12345678 -> a second done 33 clocks later with hi=lo=0. The first result stays visible until then.
